// File: rtl/threshold_pkg.sv
// Shared constants and types for the threshold editor.
package threshold_pkg;

    localparam int BOUND_W = 12;
    localparam int DIGIT_W = 4;
    localparam int NDIG    = BOUND_W / DIGIT_W;

    localparam logic [BOUND_W-1:0] LOWER_RST = '0;
    localparam logic [BOUND_W-1:0] UPPER_RST = '1;

    typedef logic [BOUND_W-1:0] bound_t;
    typedef logic [1:0]         digit_t;

endpackage

// File: rtl/threshold_input_btn_edge.sv
// One-bit rising-edge detector. The pulse is combinational from the live
// input so that the registered consumer acts on the same clock edge where the
// button is first seen high.
module btn_edge (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic btn_i,
    output logic edge_o
);

    logic prev_q;

    // Remember the button level seen at the previous clock edge.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= btn_i;
        end
    end

    assign edge_o = btn_i & ~prev_q;

endmodule

// File: rtl/threshold_input.sv
// Button-driven editor for a lower/upper threshold pair. A cursor selects a
// hex digit; up/down step that digit with saturation so the bounds never wrap
// and lower never exceeds upper.
module threshold_input #(
    parameter int                                  BOUND_W   = threshold_pkg::BOUND_W,
    parameter int                                  DIGIT_W   = threshold_pkg::DIGIT_W,
    parameter logic [threshold_pkg::BOUND_W-1:0]   LOWER_RST = threshold_pkg::LOWER_RST,
    parameter logic [threshold_pkg::BOUND_W-1:0]   UPPER_RST = threshold_pkg::UPPER_RST
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               btnu,
    input  logic               btnd,
    input  logic               btnl,
    input  logic               btnr,
    input  logic               threshold_on,
    input  logic               threshold_lowhi,
    output logic [BOUND_W-1:0] lower_bound_out,
    output logic [BOUND_W-1:0] upper_bound_out,
    output logic [1:0]         digit_sel_out
);

    import threshold_pkg::*;

    localparam int                    NDIG_L   = BOUND_W / DIGIT_W;
    localparam int                    W1       = BOUND_W + 1;
    localparam logic [W1-1:0]         BMAX     = {1'b0, {BOUND_W{1'b1}}};
    localparam digit_t                DIG_TOP  = digit_t'(NDIG_L - 1);

    logic eu, ed, el, er;

    btn_edge u_edge_u (.clk_i(clk_in), .rst_ni(rst_in), .btn_i(btnu), .edge_o(eu));
    btn_edge u_edge_d (.clk_i(clk_in), .rst_ni(rst_in), .btn_i(btnd), .edge_o(ed));
    btn_edge u_edge_l (.clk_i(clk_in), .rst_ni(rst_in), .btn_i(btnl), .edge_o(el));
    btn_edge u_edge_r (.clk_i(clk_in), .rst_ni(rst_in), .btn_i(btnr), .edge_o(er));

    logic [BOUND_W-1:0] lower_q, lower_d;
    logic [BOUND_W-1:0] upper_q, upper_d;
    digit_t             digit_sel_q, digit_sel_d;

    logic [W1-1:0] step, sel, lim_hi, lim_lo, sum, up_tgt, dn_tgt, target;
    logic          do_step;

    // Saturating step datapath plus cursor movement; step uses the old cursor.
    always_comb begin
        step    = W1'(1) << (DIGIT_W * int'(digit_sel_q));
        sel     = threshold_lowhi ? {1'b0, upper_q} : {1'b0, lower_q};
        lim_hi  = threshold_lowhi ? BMAX : {1'b0, upper_q};
        lim_lo  = threshold_lowhi ? {1'b0, lower_q} : '0;
        sum     = sel + step;
        up_tgt  = (sum > lim_hi) ? lim_hi : sum;
        // sel - step < lim_lo rewritten to avoid an underflowing subtract
        dn_tgt  = (sel < lim_lo + step) ? lim_lo : sel - step;
        target  = sel;
        do_step = 1'b0;
        lower_d     = lower_q;
        upper_d     = upper_q;
        digit_sel_d = digit_sel_q;

        if (threshold_on) begin
            if (eu && !ed) begin
                target  = up_tgt;
                do_step = 1'b1;
            end else if (ed && !eu) begin
                target  = dn_tgt;
                do_step = 1'b1;
            end

            if (do_step) begin
                if (threshold_lowhi) begin
                    upper_d = target[BOUND_W-1:0];
                end else begin
                    lower_d = target[BOUND_W-1:0];
                end
            end

            if (el && !er && digit_sel_q != DIG_TOP) begin
                digit_sel_d = digit_sel_q + 2'd1;
            end else if (er && !el && digit_sel_q != 2'd0) begin
                digit_sel_d = digit_sel_q - 2'd1;
            end
        end
    end

    // Bound and cursor registers.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            lower_q     <= LOWER_RST;
            upper_q     <= UPPER_RST;
            digit_sel_q <= 2'd0;
        end else begin
            lower_q     <= lower_d;
            upper_q     <= upper_d;
            digit_sel_q <= digit_sel_d;
        end
    end

    assign lower_bound_out = lower_q;
    assign upper_bound_out = upper_q;
    assign digit_sel_out   = digit_sel_q;

endmodule

// File: tb/tb_threshold_input.sv
// Bench for threshold_input: directed button sequences, an integer model of
// the editing rules, a per-cycle compare process and literal spot checks.
module tb_threshold_input;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b0;
    logic        btnu = 1'b0, btnd = 1'b0, btnl = 1'b0, btnr = 1'b0;
    logic        threshold_on = 1'b0;
    logic        threshold_lowhi = 1'b0;
    logic [11:0] lower_bound_out;
    logic [11:0] upper_bound_out;
    logic [1:0]  digit_sel_out;

    int tests = 0;
    int fails = 0;
    bit cmp_en = 1'b0;

    threshold_input dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .btnu            (btnu),
        .btnd            (btnd),
        .btnl            (btnl),
        .btnr            (btnr),
        .threshold_on    (threshold_on),
        .threshold_lowhi (threshold_lowhi),
        .lower_bound_out (lower_bound_out),
        .upper_bound_out (upper_bound_out),
        .digit_sel_out   (digit_sel_out)
    );

    // clock / reset
    always #5 clk_in = ~clk_in;

    // ---------------- model ----------------
    int m_lower = 0, m_upper = 4095, m_dsel = 0;
    bit pu = 0, pd = 0, pl = 0, pr = 0;

    always @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            m_lower = 0; m_upper = 4095; m_dsel = 0;
            pu = 0; pd = 0; pl = 0; pr = 0;
        end else begin
            bit eu, ed, el, er;
            int stp, cur, hi, lo, tgt;
            eu = btnu && !pu; ed = btnd && !pd;
            el = btnl && !pl; er = btnr && !pr;
            pu = btnu; pd = btnd; pl = btnl; pr = btnr;
            if (threshold_on) begin
                stp = 1;
                for (int k = 0; k < m_dsel; k++) stp = stp * 16;
                cur = threshold_lowhi ? m_upper : m_lower;
                hi  = threshold_lowhi ? 4095 : m_upper;
                lo  = threshold_lowhi ? m_lower : 0;
                tgt = cur;
                if (eu && !ed) tgt = (cur + stp > hi) ? hi : cur + stp;
                if (ed && !eu) tgt = (cur - stp < lo) ? lo : cur - stp;
                if (threshold_lowhi) m_upper = tgt; else m_lower = tgt;
                if (el && !er) m_dsel = (m_dsel + 1 > 2) ? 2 : m_dsel + 1;
                if (er && !el) m_dsel = (m_dsel - 1 < 0) ? 0 : m_dsel - 1;
            end
        end
    end

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input int got, input int exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Every-cycle compare against the model, away from the active edge.
    always @(negedge clk_in) begin
        if (cmp_en) begin
            check("cyc_lower", int'(lower_bound_out), m_lower);
            check("cyc_upper", int'(upper_bound_out), m_upper);
            check("cyc_dsel",  int'(digit_sel_out),   m_dsel);
        end
    end

    // Literal pin: both DUT and model must show the hand-computed values.
    task automatic pin(input string name, input int lo, input int up, input int ds);
        check({name, "_lower"}, int'(lower_bound_out), lo);
        check({name, "_upper"}, int'(upper_bound_out), up);
        check({name, "_dsel"},  int'(digit_sel_out),   ds);
        check({name, "_mlower"}, m_lower, lo);
        check({name, "_mupper"}, m_upper, up);
        check({name, "_mdsel"},  m_dsel,  ds);
    endtask

    // ---------------- drivers ----------------
    task automatic cycles(input int n);
        repeat (n) @(negedge clk_in);
    endtask

    // Raise the given buttons for one clock, then release for one clock.
    task automatic pulse(input bit u, input bit d, input bit l, input bit r);
        btnu = u; btnd = d; btnl = l; btnr = r;
        cycles(1);
        btnu = 0; btnd = 0; btnl = 0; btnr = 0;
        cycles(1);
    endtask

    task automatic pulse_n(input bit u, input bit d, input bit l, input bit r, input int n);
        for (int i = 0; i < n; i++) pulse(u, d, l, r);
    endtask

    initial begin
        cycles(3);
        rst_in = 1'b1;
        cmp_en = 1'b1;
        cycles(1);
        pin("reset", 0, 4095, 0);

        // disabled: no effect
        threshold_on = 0;
        pulse(1, 0, 0, 0);
        pin("disabled", 0, 4095, 0);

        threshold_on = 1; threshold_lowhi = 0;
        pulse(1, 0, 0, 0);
        pin("up1", 1, 4095, 0);
        pulse(1, 0, 0, 0);
        pin("up2", 2, 4095, 0);

        // hold for 5 cycles: single step
        btnu = 1; cycles(5); btnu = 0; cycles(1);
        pin("hold", 3, 4095, 0);

        pulse(0, 1, 0, 0);
        pin("dn_a", 2, 4095, 0);
        pulse(0, 1, 0, 0);
        pin("dn_b", 1, 4095, 0);
        pulse(0, 1, 0, 0);
        pin("dn_c", 0, 4095, 0);
        pulse(0, 1, 0, 0);
        pin("dn_sat0", 0, 4095, 0);

        // cursor and digit-1 step
        pulse(0, 0, 1, 0);
        pin("curl", 0, 4095, 1);
        pulse(1, 0, 0, 0);
        pin("up16", 16, 4095, 1);
        pulse_n(0, 0, 1, 0, 3);
        pin("cur_sat2", 16, 4095, 2);
        pulse(0, 0, 0, 1);
        pin("curr", 16, 4095, 1);

        // upper already at the top
        threshold_lowhi = 1;
        pulse(1, 0, 0, 0);
        pin("upper_sat", 16, 4095, 1);

        // lower -> 256
        threshold_lowhi = 0;
        pulse(0, 1, 0, 0);
        pin("lower0", 0, 4095, 1);
        pulse(0, 0, 1, 0);
        pulse(1, 0, 0, 0);
        pin("lower256", 256, 4095, 2);

        // upper -> 300 (0x12C)
        threshold_lowhi = 1;
        pulse_n(0, 1, 0, 0, 14);
        pin("upper511", 256, 511, 2);
        pulse(0, 0, 0, 1);
        pulse_n(0, 1, 0, 0, 13);
        pin("upper303", 256, 303, 1);
        pulse(0, 0, 0, 1);
        pulse_n(0, 1, 0, 0, 3);
        pin("upper300", 256, 300, 0);
        pulse_n(0, 0, 1, 0, 2);

        pulse(0, 1, 0, 0);
        pin("upper_clamp", 256, 256, 2);
        threshold_lowhi = 0;
        pulse(1, 0, 0, 0);
        pin("lower_clamp", 256, 256, 2);

        // simultaneous up+down and left+right
        pulse(1, 1, 0, 0);
        pin("ud_same", 256, 256, 2);
        pulse(0, 0, 1, 1);
        pin("lr_same", 256, 256, 2);

        // cursor move plus step together: step uses the old cursor (256)
        pulse(0, 1, 0, 1);
        pin("mv_step", 0, 256, 1);

        // button held while enable turns on: no action
        threshold_on = 0;
        btnu = 1; cycles(2);
        threshold_on = 1; cycles(2);
        btnu = 0; cycles(1);
        pin("held_enable", 0, 256, 1);

        // asynchronous reset between clock edges
        pulse(1, 0, 0, 0);
        pin("pre_rst", 16, 256, 1);
        @(posedge clk_in);
        #2 rst_in = 1'b0;
        #1;
        pin("async_rst", 0, 4095, 0);
        cycles(2);
        rst_in = 1'b1;
        cycles(1);
        pin("post_rst", 0, 4095, 0);
        pulse(1, 0, 0, 0);
        pin("after_rst_up", 1, 4095, 0);

        cmp_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
